// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg (package)
// Description : Shared types and constants for the sequential binary-to-BCD
//               converter (bin_to_bcd_seq) and its add-3 correction cell.
//               Contents:
//                 bcd_state_t - converter FSM state (IDLE, SHIFT)
//                 DIGIT_W     - bits per BCD digit
//                 SEG_BLANK   - 7-segment pattern for an unlit (blanked) digit
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } bcd_state_t;

    localparam int DIGIT_W = 4;

    // Active-low segments: all ones turns every segment off.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ============================================================================
// Module      : bcd_add3
// Description : Combinational double-dabble correction for one BCD digit.
//               Adds 3 to any digit that is 5 or more, so that the following
//               left shift carries correctly into the next decimal digit.
// Ports       : i_digit [DIGIT_W-1:0]  scratch digit before correction
//               o_digit [DIGIT_W-1:0]  corrected digit
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit
);

    always_comb begin
        if (i_digit >= DIGIT_W'(5)) begin
            o_digit = i_digit + DIGIT_W'(3);
        end else begin
            o_digit = i_digit;
        end
    end

endmodule : bcd_add3
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_seq
// Description : Sequential shift-and-add-3 (double-dabble) binary-to-BCD
//               converter. One input bit is consumed per clock, so a
//               conversion takes BIN_W clocks from the accepting edge to the
//               done pulse. Results are held between conversions.
// Parameters  : BIN_W   binary input width / shift cycles per conversion
//               DIGITS  number of BCD digits produced
// Ports       : clk       system clock, rising edge
//               reset     asynchronous active-high reset, clears all state
//               start     conversion request, sampled only in IDLE
//               bin_in    unsigned binary value, captured on accepting edge
//               busy      high while converting
//               done      one-cycle pulse when bcd_out/overflow update
//               bcd_out   digit i at [4i+3:4i], digit 0 = ones (registered)
//               overflow  value exceeded DIGITS digits (registered)
//               blank     leading-zero mask per digit (blank[0] always 0)
// Config      : BCD_BLANK_EN - when defined, generates the registered
//               leading-zero blank mask; otherwise blank is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin_in,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                      overflow,
    output logic [DIGITS-1:0]         blank
);

    localparam int c_CNT_W = $clog2(BIN_W + 1);
    localparam int c_BCD_W = DIGIT_W * DIGITS;
    localparam int c_CAT_W = c_BCD_W + BIN_W;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    bcd_state_t            r_state;
    bcd_state_t            w_state_next;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [BIN_W-1:0]      r_shreg;
    logic [c_BCD_W-1:0]    r_scratch;
    logic                  r_cout;
    logic [c_BCD_W-1:0]    r_bcd;
    logic                  r_ovf;
    logic                  r_done;

    // ------------------------------------------------------------------
    // Combinational shift step
    // ------------------------------------------------------------------
    logic [c_BCD_W-1:0]    w_adj;
    logic [c_CAT_W-1:0]    w_cat;
    logic [c_CAT_W-1:0]    w_cat_sh;
    logic [c_BCD_W-1:0]    w_scr_next;
    logic [BIN_W-1:0]      w_shreg_next;
    logic                  w_carry;
    logic                  w_accept;
    logic                  w_last;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
        bcd_add3 u_add3 (
            .i_digit (r_scratch[DIGIT_W*gi +: DIGIT_W]),
            .o_digit (w_adj[DIGIT_W*gi +: DIGIT_W])
        );
    end

    // Corrected scratch and the remaining binary bits shift as one word;
    // the bit leaving the top digit is a decimal carry beyond DIGITS.
    assign w_cat        = {w_adj, r_shreg};
    assign w_carry      = w_cat[c_CAT_W-1];
    assign w_cat_sh     = {w_cat[c_CAT_W-2:0], 1'b0};
    assign w_scr_next   = w_cat_sh[c_CAT_W-1:BIN_W];
    assign w_shreg_next = w_cat_sh[BIN_W-1:0];

    assign w_accept = (r_state == IDLE) && start;
    assign w_last   = (r_state == SHIFT) && (r_cnt == c_CNT_W'(1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt == c_CNT_W'(1)) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_shreg   <= '0;
            r_scratch <= '0;
            r_cout    <= 1'b0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_shreg   <= bin_in;
                r_scratch <= '0;
                r_cout    <= 1'b0;
                r_cnt     <= c_CNT_W'(BIN_W);
            end else if (r_state == SHIFT) begin
                r_scratch <= w_scr_next;
                r_shreg   <= w_shreg_next;
                r_cout    <= r_cout | w_carry;
                r_cnt     <= r_cnt - c_CNT_W'(1);
                // Outputs only ever change here, all together, so a reader
                // never sees a half-converted value.
                if (w_last) begin
                    r_bcd  <= w_scr_next;
                    r_ovf  <= r_cout | w_carry;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy     = (r_state == SHIFT);
    assign done     = r_done;
    assign bcd_out  = r_bcd;
    assign overflow = r_ovf;

    // ------------------------------------------------------------------
    // Leading-zero blanking
    // ------------------------------------------------------------------
`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] r_blank;
    logic [DIGITS-1:0] w_blank_next;
    logic              w_zero_run;

    // Walk from the most significant digit down; a digit is blanked while
    // it and everything above it are zero. The ones digit always shows.
    always_comb begin
        w_blank_next = '0;
        w_zero_run   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_zero_run      = w_zero_run && (w_scr_next[DIGIT_W*i +: DIGIT_W] == '0);
            w_blank_next[i] = w_zero_run;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blank <= '0;
        end else if (w_last) begin
            r_blank <= w_blank_next;
        end
    end

    assign blank = r_blank;
`else
    assign blank = '0;
`endif

endmodule : bin_to_bcd_seq
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin_to_bcd_seq
// Description : Self-checking bench for bin_to_bcd_seq. Two instances are
//               exercised: a 3-digit converter and a 2-digit converter
//               (for the overflow path). Expected results come from a
//               decimal arithmetic model and are queued at issue time; a
//               monitor compares whenever an instance pulses done.
// Config      : BCD_BLANK_EN - when defined, expected blank masks are
//               computed; otherwise blank is expected to be 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_seq;

    localparam int BIN_W = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a, start_b;
    logic [7:0]  bin_a, bin_b;
    wire         busy_a, done_a, ovf_a;
    wire  [11:0] bcd_a;
    wire  [2:0]  blank_a;
    wire         busy_b, done_b, ovf_b;
    wire  [7:0]  bcd_b;
    wire  [1:0]  blank_b;

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(3)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .bin_in(bin_a),
        .busy(busy_a), .done(done_a), .bcd_out(bcd_a),
        .overflow(ovf_a), .blank(blank_a)
    );

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .bin_in(bin_b),
        .busy(busy_b), .done(done_b), .bcd_out(bcd_b),
        .overflow(ovf_b), .blank(blank_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [11:0] bcd;
        logic        ovf;
        logic [2:0]  blank;
        int          due;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t mon_a, mon_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Decimal reference: digits by repeated division, overflow when the
    // value needs more than d decimal digits.
    function automatic exp_t model(input int v, input int d, input int due);
        exp_t e;
        int   p;
        int   low;
        int   q;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        low     = v % p;
        e.ovf   = (v >= p);
        e.bcd   = '0;
        e.blank = '0;
        q = low;
        for (int i = 0; i < d; i++) begin
            e.bcd[4*i +: 4] = 4'(q % 10);
            q = q / 10;
        end
`ifdef BCD_BLANK_EN
        p = 10;
        for (int i = 1; i < d; i++) begin
            e.blank[i] = (low < p);
            p = p * 10;
        end
`endif
        e.due = due;
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (!reset && done_a) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_done: got done=1 expected no pending conversion (t=%0t)", $time);
            end else begin
                mon_a = q_a.pop_front();
                check("a_bcd",      32'(bcd_a),   32'(mon_a.bcd));
                check("a_overflow", 32'(ovf_a),   32'(mon_a.ovf));
                check("a_blank",    32'(blank_a), 32'(mon_a.blank));
                check("a_latency",  32'(cyc),     32'(mon_a.due));
                check("a_busy_at_done", 32'(busy_a), 32'd0);
            end
        end
        if (!reset && done_b) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_done: got done=1 expected no pending conversion (t=%0t)", $time);
            end else begin
                mon_b = q_b.pop_front();
                check("b_bcd",      32'(bcd_b),   32'(mon_b.bcd[7:0]));
                check("b_overflow", 32'(ovf_b),   32'(mon_b.ovf));
                check("b_blank",    32'(blank_b), 32'(mon_b.blank[1:0]));
                check("b_latency",  32'(cyc),     32'(mon_b.due));
                check("b_busy_at_done", 32'(busy_b), 32'd0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called at a negedge)
    // ------------------------------------------------------------------
    task automatic start_conv(input bit which, input int v, input bit expect_done);
        if (!which) begin start_a = 1'b1; bin_a = 8'(v); end
        else        begin start_b = 1'b1; bin_b = 8'(v); end
        @(posedge clk);
        #1;
        // Scramble the input right after capture; it must not matter.
        if (!which) begin
            start_a = 1'b0;
            bin_a   = 8'($urandom);
            if (expect_done) q_a.push_back(model(v, 3, cyc + BIN_W));
        end else begin
            start_b = 1'b0;
            bin_b   = 8'($urandom);
            if (expect_done) q_b.push_back(model(v, 2, cyc + BIN_W));
        end
    endtask

    task automatic pulse_start(input bit which, input int v);
        if (!which) begin start_a = 1'b1; bin_a = 8'(v); end
        else        begin start_b = 1'b1; bin_b = 8'(v); end
        @(posedge clk);
        #1;
        if (!which) start_a = 1'b0;
        else        start_b = 1'b0;
    endtask

    task automatic wait_done(input bit which);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            seen = which ? done_b : done_a;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_done_timeout: got no done on dut %0d expected done within 40 cycles", which);
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        reset   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        bin_a   = '0;
        bin_b   = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",     32'(busy_a),  32'd0);
        check("rst_done",     32'(done_a),  32'd0);
        check("rst_bcd",      32'(bcd_a),   32'd0);
        check("rst_overflow", 32'(ovf_a),   32'd0);
        check("rst_blank",    32'(blank_a), 32'd0);
        check("rst_bcd_b",    32'(bcd_b),   32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Zero input
        start_conv(0, 0, 1);
        check("t1_busy", 32'(busy_a), 32'd1);
        wait_done(0);
        @(negedge clk);
        check("t1_done_one_cycle", 32'(done_a), 32'd0);

        // Max input
        start_conv(0, 255, 1);
        wait_done(0);

        // Start while busy is ignored
        @(negedge clk);
        start_conv(0, 99, 1);
        @(negedge clk);
        @(negedge clk);
        pulse_start(0, 17);
        wait_done(0);
        repeat (12) @(negedge clk);
        check("t3_bcd_held", 32'(bcd_a), 32'h099);
        check("t3_idle",     32'(busy_a), 32'd0);

        // Reset mid-conversion
        start_conv(0, 42, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("t4_rst_busy",     32'(busy_a), 32'd0);
        check("t4_rst_done",     32'(done_a), 32'd0);
        check("t4_rst_bcd",      32'(bcd_a),  32'd0);
        check("t4_rst_overflow", 32'(ovf_a),  32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("t4_bcd_after_abort", 32'(bcd_a), 32'd0);
        start_conv(0, 42, 1);
        wait_done(0);

        // Blank patterns and back-to-back start on the done cycle
        @(negedge clk);
        start_conv(0, 7, 1);
        wait_done(0);
        start_conv(0, 0, 1);
        check("t6_b2b_busy", 32'(busy_a), 32'd1);
        wait_done(0);
        start_conv(0, 105, 1);
        wait_done(0);

        // Randomized traffic on the 3-digit converter
        for (int n = 0; n < 25; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            start_conv(0, int'($urandom_range(0, 255)), 1);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 5)) @(negedge clk);
                pulse_start(0, int'($urandom_range(0, 255)));
            end
            wait_done(0);
        end

        // 2-digit converter: overflow then recovery
        @(negedge clk);
        start_conv(1, 200, 1);
        wait_done(1);
        @(negedge clk);
        start_conv(1, 73, 1);
        wait_done(1);
        for (int n = 0; n < 20; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            start_conv(1, int'($urandom_range(0, 255)), 1);
            wait_done(1);
        end

        repeat (15) @(negedge clk);
        check("a_queue_drained", 32'(q_a.size()), 32'd0);
        check("b_queue_drained", 32'(q_b.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_bin_to_bcd_seq
`default_nettype wire
